// File: rtl/mem_map_pkg.sv
// Shared constants and the window-table entry type for the address-window decoder.
package mem_map_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned WIN_BITS_DEF = 10;
  // Prefixes are stored right-aligned in a fixed-width field so the entry type is parameter-independent
  localparam int unsigned PFX_MAX_W    = 64;
  localparam int unsigned MISS_CNT_W   = 16;
  localparam logic [MISS_CNT_W-1:0] MISS_CNT_SAT = '1;

  typedef struct packed {
    logic                 en;
    logic [PFX_MAX_W-1:0] prefix;
  } win_entry_t;

endpackage

// File: rtl/mem_window_map_win_match.sv
// Single-window comparator: flags an enabled window whose prefix equals the address prefix.
module win_match
  import mem_map_pkg::*;
(
  input  win_entry_t           entry,
  input  logic [PFX_MAX_W-1:0] addr_pfx,
  output logic                 match_c
);

  assign match_c = entry.en && (entry.prefix == addr_pfx);

endmodule

// File: rtl/mem_window_map.sv
// Programmable address-window decoder with registered response and sticky miss statistics.
// Optional overlap detection is built when MEM_WINDOW_OVERLAP_CHK_EN is defined.
module mem_window_map
  import mem_map_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned WIN_BITS = WIN_BITS_DEF,
  parameter int unsigned NUM_WIN  = 4,
  parameter int unsigned IDX_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_prefix,
  input  logic                  cfg_en,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  rsp_valid,
  output logic [NUM_WIN-1:0]    rsp_sel,
  output logic [IDX_W-1:0]      rsp_idx,
  output logic [WIN_BITS-1:0]   rsp_ram_addr,
  output logic                  rsp_miss,
  input  logic                  clr_stats,
  output logic [MISS_CNT_W-1:0] miss_count,
  output logic [ADDR_W-1:0]     first_miss_addr
`ifdef MEM_WINDOW_OVERLAP_CHK_EN
  ,
  output logic                  overlap_err
`endif
);

  win_entry_t tbl_q [NUM_WIN];
  win_entry_t tbl_d [NUM_WIN];

  logic [PFX_MAX_W-1:0]  req_pfx;
  logic [PFX_MAX_W-1:0]  cfg_pfx;
  logic [NUM_WIN-1:0]    match;
  logic [NUM_WIN-1:0]    sel_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  hit_c;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [NUM_WIN-1:0]    rsp_sel_q, rsp_sel_d;
  logic [IDX_W-1:0]      rsp_idx_q, rsp_idx_d;
  logic [WIN_BITS-1:0]   rsp_ram_addr_q, rsp_ram_addr_d;
  logic                  rsp_miss_q, rsp_miss_d;
  logic [MISS_CNT_W-1:0] miss_count_q, miss_count_d;
  logic [ADDR_W-1:0]     first_miss_addr_q, first_miss_addr_d;

  assign req_pfx = PFX_MAX_W'(req_addr >> WIN_BITS);
  assign cfg_pfx = PFX_MAX_W'(cfg_prefix >> WIN_BITS);

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    win_match u_match (
      .entry    (tbl_q[g]),
      .addr_pfx (req_pfx),
      .match_c  (match[g])
    );
  end

  // Lowest matching index wins; scanning downward lets the lowest overwrite
  always_comb begin
    sel_c = '0;
    idx_c = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_c    = '0;
        sel_c[i] = 1'b1;
        idx_c    = IDX_W'(i);
      end
    end
  end

  assign hit_c = |match;

  // Out-of-range indices never equal any loop value, so such writes drop out
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          tbl_d[i].en     = cfg_en;
          tbl_d[i].prefix = cfg_pfx;
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d       = req_valid;
    rsp_sel_d         = req_valid ? sel_c : '0;
    rsp_miss_d        = req_valid && !hit_c;
    rsp_idx_d         = req_valid ? idx_c : rsp_idx_q;
    rsp_ram_addr_d    = req_valid ? req_addr[WIN_BITS-1:0] : rsp_ram_addr_q;
    miss_count_d      = miss_count_q;
    first_miss_addr_d = first_miss_addr_q;
    if (clr_stats) begin
      miss_count_d      = '0;
      first_miss_addr_d = '0;
    end else if (rsp_miss_d) begin
      if (miss_count_q == '0) first_miss_addr_d = req_addr;
      if (miss_count_q != MISS_CNT_SAT) miss_count_d = miss_count_q + MISS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WIN; i++) tbl_q[i] <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_sel_q         <= '0;
      rsp_idx_q         <= '0;
      rsp_ram_addr_q    <= '0;
      rsp_miss_q        <= 1'b0;
      miss_count_q      <= '0;
      first_miss_addr_q <= '0;
    end else begin
      tbl_q             <= tbl_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_sel_q         <= rsp_sel_d;
      rsp_idx_q         <= rsp_idx_d;
      rsp_ram_addr_q    <= rsp_ram_addr_d;
      rsp_miss_q        <= rsp_miss_d;
      miss_count_q      <= miss_count_d;
      first_miss_addr_q <= first_miss_addr_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_sel         = rsp_sel_q;
  assign rsp_idx         = rsp_idx_q;
  assign rsp_ram_addr    = rsp_ram_addr_q;
  assign rsp_miss        = rsp_miss_q;
  assign miss_count      = miss_count_q;
  assign first_miss_addr = first_miss_addr_q;

`ifdef MEM_WINDOW_OVERLAP_CHK_EN
  logic multi_c;
  logic overlap_err_q, overlap_err_d;

  // Clearing the lowest set bit leaves something only when two or more windows match
  assign multi_c = |(match & (match - NUM_WIN'(1)));

  always_comb begin
    overlap_err_d = overlap_err_q;
    if (clr_stats)                 overlap_err_d = 1'b0;
    else if (req_valid && multi_c) overlap_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) overlap_err_q <= 1'b0;
    else       overlap_err_q <= overlap_err_d;
  end

  assign overlap_err = overlap_err_q;
`endif

endmodule

// File: tb/tb_mem_window_map.sv
// Scoreboard bench for mem_window_map: directed test-plan scenarios plus randomized traffic
// checked against an address-arithmetic reference model (define MEM_WINDOW_OVERLAP_CHK_EN to cover overlap_err).
module tb_mem_window_map;

  localparam int unsigned WB = 10;
  localparam int unsigned NW = 4;

  logic        clk = 1'b0;
  logic        reset, cfg_we, cfg_en, req_valid, clr_stats;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_prefix, req_addr;
  logic        rsp_valid, rsp_miss;
  logic [3:0]  rsp_sel;
  logic [1:0]  rsp_idx;
  logic [9:0]  rsp_ram_addr;
  logic [15:0] miss_count;
  logic [31:0] first_miss_addr;
`ifdef MEM_WINDOW_OVERLAP_CHK_EN
  logic        overlap_err;
`endif

  mem_window_map dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_we          (cfg_we),
    .cfg_idx         (cfg_idx),
    .cfg_prefix      (cfg_prefix),
    .cfg_en          (cfg_en),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .rsp_valid       (rsp_valid),
    .rsp_sel         (rsp_sel),
    .rsp_idx         (rsp_idx),
    .rsp_ram_addr    (rsp_ram_addr),
    .rsp_miss        (rsp_miss),
    .clr_stats       (clr_stats),
    .miss_count      (miss_count),
    .first_miss_addr (first_miss_addr)
`ifdef MEM_WINDOW_OVERLAP_CHK_EN
    ,
    .overlap_err     (overlap_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] idx;
    logic [9:0] ram;
    logic       miss;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 0;

  // Reference model state
  bit          m_en [NW];
  int unsigned m_pfx [NW];
  int unsigned m_cnt;
  logic [31:0] m_first;
  bit          m_ovl;
  logic [1:0]  m_last_idx;
  logic [9:0]  m_last_ram;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) begin
      m_en[i]  = 0;
      m_pfx[i] = 0;
    end
    m_cnt      = 0;
    m_first    = '0;
    m_ovl      = 0;
    m_last_idx = '0;
    m_last_ram = '0;
  endfunction

  // Drive one cycle of inputs, advance the model, return one cycle later at negedge+1
  task automatic step(input bit v, input logic [31:0] a, input bit we, input int idx,
                      input logic [31:0] pfx, input bit en, input bit clr, input bit rst);
    exp_t e;
    int   nmatch;
    reset = rst; req_valid = v; req_addr = a; cfg_we = we; cfg_idx = 2'(idx);
    cfg_prefix = pfx; cfg_en = en; clr_stats = clr;
    if (rst) begin
      model_reset();
    end else begin
      if (v) begin
        nmatch = 0;
        e.sel = '0; e.idx = '0; e.miss = 1'b1;
        e.ram = 10'(a % (1 << WB));
        for (int i = 0; i < NW; i++) begin
          if (m_en[i] && m_pfx[i] == (a >> WB)) begin
            if (nmatch == 0) begin
              e.sel  = 4'(1 << i);
              e.idx  = 2'(i);
              e.miss = 1'b0;
            end
            nmatch++;
          end
        end
        exp_q.push_back(e);
        m_last_idx = e.idx;
        m_last_ram = e.ram;
        if (e.miss && !clr) begin
          if (m_cnt == 0) m_first = a;
          if (m_cnt < 65535) m_cnt++;
        end
        if (nmatch >= 2) m_ovl = 1;
      end
      if (clr) begin
        m_cnt = 0; m_first = '0; m_ovl = 0;
      end
      if (we && idx < NW) begin
        m_en[idx]  = en;
        m_pfx[idx] = pfx >> WB;
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp_valid", 64'(rsp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_sel", 64'(rsp_sel), 64'(e.sel));
          chk("rsp_idx", 64'(rsp_idx), 64'(e.idx));
          chk("rsp_ram_addr", 64'(rsp_ram_addr), 64'(e.ram));
          chk("rsp_miss", 64'(rsp_miss), 64'(e.miss));
        end
      end else begin
        if (exp_q.size() != 0) begin
          chk("missing_rsp_valid", 64'(rsp_valid), 64'(1));
          void'(exp_q.pop_front());
        end
        chk("idle_sel", 64'(rsp_sel), 64'(0));
        chk("idle_miss", 64'(rsp_miss), 64'(0));
        chk("idle_idx_hold", 64'(rsp_idx), 64'(m_last_idx));
        chk("idle_ram_hold", 64'(rsp_ram_addr), 64'(m_last_ram));
      end
      chk("miss_count", 64'(miss_count), 64'(m_cnt));
      chk("first_miss_addr", 64'(first_miss_addr), 64'(m_first));
`ifdef MEM_WINDOW_OVERLAP_CHK_EN
      chk("overlap_err", 64'(overlap_err), 64'(m_ovl));
`endif
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    model_reset();
    reset = 1'b1; req_valid = 0; req_addr = '0; cfg_we = 0; cfg_idx = '0;
    cfg_prefix = '0; cfg_en = 0; clr_stats = 0;
    @(negedge clk); #1;
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, 1);

    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_sel", 64'(rsp_sel), 64'(0));
    chk("reset_rsp_idx", 64'(rsp_idx), 64'(0));
    chk("reset_rsp_ram_addr", 64'(rsp_ram_addr), 64'(0));
    chk("reset_rsp_miss", 64'(rsp_miss), 64'(0));
    chk("reset_miss_count", 64'(miss_count), 64'(0));
    chk("reset_first_miss", 64'(first_miss_addr), 64'(0));
`ifdef MEM_WINDOW_OVERLAP_CHK_EN
    chk("reset_overlap_err", 64'(overlap_err), 64'(0));
`endif
    mon_en = 1;

    // Single window
    step(0, 32'h0, 1, 1, 32'h0000_0400, 1, 0, 0);
    step(1, 32'h0000_0734, 0, 0, 32'h0, 0, 0, 0);
    chk("single_sel", 64'(rsp_sel), 64'(4'b0010));
    chk("single_idx", 64'(rsp_idx), 64'(1));
    chk("single_ram", 64'(rsp_ram_addr), 64'(10'h334));
    chk("single_miss", 64'(rsp_miss), 64'(0));

    // Miss statistics then clear
    step(1, 32'h0000_1000, 0, 0, 32'h0, 0, 0, 0);
    chk("miss1_pulse", 64'(rsp_miss), 64'(1));
    step(1, 32'h0000_2000, 0, 0, 32'h0, 0, 0, 0);
    chk("miss2_pulse", 64'(rsp_miss), 64'(1));
    chk("miss_count_2", 64'(miss_count), 64'(2));
    chk("first_miss_1000", 64'(first_miss_addr), 64'(32'h0000_1000));
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 0);
    chk("clr_count", 64'(miss_count), 64'(0));
    chk("clr_first", 64'(first_miss_addr), 64'(0));

    // Config write colliding with a request decodes against the old table
    step(1, 32'h0000_1000, 1, 0, 32'h0000_1000, 1, 0, 0);
    chk("collide_miss", 64'(rsp_miss), 64'(1));
    step(1, 32'h0000_1000, 0, 0, 32'h0, 0, 0, 0);
    chk("collide_then_hit", 64'(rsp_sel), 64'(4'b0001));

    // Overlapping windows resolve to the lowest index
    step(0, 32'h0, 1, 2, 32'h0000_0800, 1, 0, 0);
    step(0, 32'h0, 1, 3, 32'h0000_0ABC, 1, 0, 0);
    step(1, 32'h0000_0810, 0, 0, 32'h0, 0, 0, 0);
    chk("overlap_sel", 64'(rsp_sel), 64'(4'b0100));
    chk("overlap_idx", 64'(rsp_idx), 64'(2));
`ifdef MEM_WINDOW_OVERLAP_CHK_EN
    chk("overlap_flag", 64'(overlap_err), 64'(1));
`endif
    step(1, 32'h0000_0734, 0, 0, 32'h0, 0, 0, 0);
`ifdef MEM_WINDOW_OVERLAP_CHK_EN
    chk("overlap_sticky", 64'(overlap_err), 64'(1));
`endif
    // Clear coinciding with a miss: response still flags the miss, stats stay clear
    step(1, 32'h0000_7000, 0, 0, 32'h0, 0, 1, 0);
    chk("clr_wins_miss", 64'(rsp_miss), 64'(1));
    chk("clr_wins_count", 64'(miss_count), 64'(0));

    // Randomized traffic over eight 1 KB regions so hits, misses and overlaps all occur
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      step((r % 10) < 7, 32'($urandom_range(0, 8 * 1024 - 1)),
           ((r >> 4) % 100) < 15, int'($urandom_range(0, 3)),
           32'($urandom_range(0, 7) * 1024 + $urandom_range(0, 1023)),
           ((r >> 12) % 4) != 0, ((r >> 16) % 100) < 3, ((r >> 24) % 100) < 1);
    end

    // Saturation
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 1, 1, 32'h0000_0400, 1, 0, 0);
    for (int n = 0; n < 65540; n++) begin
      step(1, 32'h0001_0000 + 32'(n % 4096), 0, 0, 32'h0, 0, 0, 0);
    end
    chk("sat_count", 64'(miss_count), 64'(16'hFFFF));
    chk("sat_first", 64'(first_miss_addr), 64'(32'h0001_0000));

    // Reset together with a request
    step(1, 32'h0000_0734, 0, 0, 32'h0, 0, 0, 1);
    chk("rst_req_valid", 64'(rsp_valid), 64'(0));
    chk("rst_req_count", 64'(miss_count), 64'(0));
    step(1, 32'h0000_0734, 0, 0, 32'h0, 0, 0, 0);
    chk("post_rst_miss", 64'(rsp_miss), 64'(1));
    chk("post_rst_sel", 64'(rsp_sel), 64'(0));

    step(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
